ysyx_idu_stage: RTL and testbench



---
 rtl/ysyx_idu_pkg.sv | 67 ++++++
 rtl/ysyx_idu_dec.sv | 157 +++++++++++++++
 rtl/ysyx_idu_stage.sv | 117 +++++++++++
 tb/tb_ysyx_idu_stage.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_idu_pkg.sv
// Shared RV32I decode encodings for the npc core; imported by the IDU, EXU and LSU.
// The dec_ctrl_t field order is the core-wide control bundle layout.
package ysyx_idu_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [1:0] WR_NONE = 2'b00;
    localparam logic [1:0] WR_PC4  = 2'b01;
    localparam logic [1:0] WR_ALU  = 2'b10;
    localparam logic [1:0] WR_MEM  = 2'b11;

    localparam logic [2:0] BR_NONE = 3'b000;
    localparam logic [2:0] BR_BEQ  = 3'b010;
    localparam logic [2:0] BR_BNE  = 3'b011;
    localparam logic [2:0] BR_BLT  = 3'b100;
    localparam logic [2:0] BR_BGE  = 3'b101;
    localparam logic [2:0] BR_BLTU = 3'b110;
    localparam logic [2:0] BR_BGEU = 3'b111;

    localparam logic [2:0] DM_RD_LB  = 3'b001;
    localparam logic [2:0] DM_RD_LBU = 3'b010;
    localparam logic [2:0] DM_RD_LH  = 3'b011;
    localparam logic [2:0] DM_RD_LHU = 3'b100;
    localparam logic [2:0] DM_RD_LW  = 3'b101;

    localparam logic [1:0] DM_WR_SB = 2'b01;
    localparam logic [1:0] DM_WR_SH = 2'b10;
    localparam logic [1:0] DM_WR_SW = 2'b11;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_LUI = 4'b1110;

    localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

    typedef struct packed {
        logic       rf_wr_en;
        logic [1:0] rf_wr_sel;
        logic       do_jump;
        logic [2:0] br_type;
        logic       alu_a_sel;
        logic       alu_b_sel;
        logic [3:0] alu_ctrl;
        logic [2:0] dm_rd_sel;
        logic [1:0] dm_wr_sel;
        logic       is_ebreak;
        logic       is_ecall;
        logic       illegal;
    } dec_ctrl_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } skid_state_e;

endpackage

// File: rtl/ysyx_idu_dec.sv
// Combinational RV32I decoder: instruction word to control bundle, immediate and
// register indices. Illegal encodings collapse the bundle to just the illegal flag.
module ysyx_idu_dec
    import ysyx_idu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst,
    output dec_ctrl_t       ctrl,
    output logic [XLEN-1:0] imm,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd
);

    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic signed [31:0] imm32;
    logic              legal;
    dec_ctrl_t         c;

    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];
    assign funct7 = inst[31:25];
    assign rs1    = inst[19:15];
    assign rs2    = inst[24:20];
    assign rd     = inst[11:7];

    always_comb begin
        c     = '0;
        imm32 = '0;
        legal = 1'b1;
        case (opcode)
            OP_LUI: begin
                c.rf_wr_en  = 1'b1;
                c.rf_wr_sel = WR_ALU;
                c.alu_b_sel = 1'b1;
                c.alu_ctrl  = ALU_LUI;
                imm32       = {inst[31:12], 12'b0};
            end
            OP_AUIPC: begin
                c.rf_wr_en  = 1'b1;
                c.rf_wr_sel = WR_ALU;
                c.alu_b_sel = 1'b1;
                imm32       = {inst[31:12], 12'b0};
            end
            OP_JAL: begin
                c.rf_wr_en  = 1'b1;
                c.rf_wr_sel = WR_PC4;
                c.do_jump   = 1'b1;
                c.alu_b_sel = 1'b1;
                imm32       = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            end
            OP_JALR: begin
                c.rf_wr_en  = 1'b1;
                c.rf_wr_sel = WR_PC4;
                c.do_jump   = 1'b1;
                c.alu_a_sel = 1'b1;
                c.alu_b_sel = 1'b1;
                imm32       = {{20{inst[31]}}, inst[31:20]};
                legal       = (funct3 == 3'b000);
            end
            OP_BRANCH: begin
                c.alu_b_sel = 1'b1;
                imm32       = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
                case (funct3)
                    3'b000:  c.br_type = BR_BEQ;
                    3'b001:  c.br_type = BR_BNE;
                    3'b100:  c.br_type = BR_BLT;
                    3'b101:  c.br_type = BR_BGE;
                    3'b110:  c.br_type = BR_BLTU;
                    3'b111:  c.br_type = BR_BGEU;
                    default: legal     = 1'b0;
                endcase
            end
            OP_LOAD: begin
                c.rf_wr_en  = 1'b1;
                c.rf_wr_sel = WR_MEM;
                c.alu_a_sel = 1'b1;
                c.alu_b_sel = 1'b1;
                imm32       = {{20{inst[31]}}, inst[31:20]};
                case (funct3)
                    3'b000:  c.dm_rd_sel = DM_RD_LB;
                    3'b100:  c.dm_rd_sel = DM_RD_LBU;
                    3'b001:  c.dm_rd_sel = DM_RD_LH;
                    3'b101:  c.dm_rd_sel = DM_RD_LHU;
                    3'b010:  c.dm_rd_sel = DM_RD_LW;
                    default: legal       = 1'b0;
                endcase
            end
            OP_STORE: begin
                c.alu_a_sel = 1'b1;
                c.alu_b_sel = 1'b1;
                imm32       = {{20{inst[31]}}, inst[31:25], inst[11:7]};
                case (funct3)
                    3'b000:  c.dm_wr_sel = DM_WR_SB;
                    3'b001:  c.dm_wr_sel = DM_WR_SH;
                    3'b010:  c.dm_wr_sel = DM_WR_SW;
                    default: legal       = 1'b0;
                endcase
            end
            OP_IMM: begin
                c.rf_wr_en  = 1'b1;
                c.rf_wr_sel = WR_ALU;
                c.alu_a_sel = 1'b1;
                c.alu_b_sel = 1'b1;
                c.alu_ctrl  = {1'b0, funct3};
                imm32       = {{20{inst[31]}}, inst[31:20]};
                // Only the shift forms constrain the upper immediate bits.
                if (funct3 == 3'b001) begin
                    legal = (funct7 == 7'b0000000);
                end else if (funct3 == 3'b101) begin
                    legal       = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
                    c.alu_ctrl[3] = funct7[5];
                end
            end
            OP_REG: begin
                c.rf_wr_en  = 1'b1;
                c.rf_wr_sel = WR_ALU;
                c.alu_a_sel = 1'b1;
                c.alu_ctrl  = {1'b0, funct3};
                if (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)) begin
                    c.alu_ctrl[3] = 1'b1;
                end else if (funct7 != 7'b0000000) begin
                    legal = 1'b0;
                end
            end
            OP_FENCE: begin
                c.alu_a_sel = 1'b1;
                c.alu_b_sel = 1'b1;
                imm32       = {{20{inst[31]}}, inst[31:20]};
                legal       = (funct3 == 3'b000);
            end
            OP_SYSTEM: begin
                c.alu_a_sel = 1'b1;
                c.alu_b_sel = 1'b1;
                imm32       = {{20{inst[31]}}, inst[31:20]};
                c.is_ecall  = (inst == INST_ECALL);
                c.is_ebreak = (inst == INST_EBREAK);
                legal       = c.is_ecall || c.is_ebreak;
            end
            default: legal = 1'b0;
        endcase
        if (rd == 5'd0) begin
            c.rf_wr_en = 1'b0;
        end
        if (!legal) begin
            c         = '0;
            c.illegal = 1'b1;
        end
    end

    assign ctrl = c;
    assign imm  = XLEN'(imm32);

endmodule

// File: rtl/ysyx_idu_stage.sv
// IDU pipeline stage: decodes on accept and holds results in a one- or two-entry
// FIFO so EXU backpressure and flushes never drop or duplicate an instruction.
module ysyx_idu_stage
    import ysyx_idu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter bit SKID_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_imm,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output dec_ctrl_t       out_ctrl
);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        dec_ctrl_t       ctrl;
    } entry_t;

    dec_ctrl_t       dec_ctrl;
    logic [XLEN-1:0] dec_imm;
    logic [4:0]      dec_rs1, dec_rs2, dec_rd;
    entry_t          dec_ent;
    entry_t          head_q, head_d, tail_q, tail_d;
    skid_state_e     state_q, state_d;
    logic            in_ready_q, in_ready_d;
    logic            accept, drain;

    ysyx_idu_dec #(.XLEN(XLEN)) u_dec (
        .inst (in_inst),
        .ctrl (dec_ctrl),
        .imm  (dec_imm),
        .rs1  (dec_rs1),
        .rs2  (dec_rs2),
        .rd   (dec_rd)
    );

    assign dec_ent   = {in_pc, dec_imm, dec_rs1, dec_rs2, dec_rd, dec_ctrl};
    assign out_valid = (state_q != ST_EMPTY);
    assign in_ready  = SKID_EN ? in_ready_q : (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign drain     = out_valid && out_ready;

    // head_q is always the oldest entry; tail_q only holds the second one in TWO.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        head_d  = dec_ent;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && drain) begin
                        head_d = dec_ent;
                    end else if (accept) begin
                        tail_d  = dec_ent;
                        state_d = ST_TWO;
                    end else if (drain) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (drain) begin
                        head_d  = tail_q;
                        state_d = ST_ONE;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
        in_ready_d = (state_d != ST_TWO);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
            head_q     <= '0;
            tail_q     <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
        end
    end

    assign out_pc   = head_q.pc;
    assign out_imm  = head_q.imm;
    assign out_rs1  = head_q.rs1;
    assign out_rs2  = head_q.rs2;
    assign out_rd   = head_q.rd;
    assign out_ctrl = head_q.ctrl;

endmodule

// File: tb/tb_ysyx_idu_stage.sv
// Scoreboard bench for ysyx_idu_stage: directed RV32I words with hand-decoded
// expectations, backpressure, flush, async reset and a 64-bit instance.
module tb_ysyx_idu_stage;
    import ysyx_idu_pkg::*;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        dec_ctrl_t   ctrl;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, flush, out_valid, out_ready;
    logic [31:0] in_inst, in_pc, out_pc, out_imm;
    logic [4:0]  out_rs1, out_rs2, out_rd;
    dec_ctrl_t   out_ctrl;

    logic        in64_valid, in64_ready, out64_valid, out64_ready;
    logic [31:0] in64_inst;
    logic [63:0] in64_pc, out64_pc, out64_imm;
    logic [4:0]  out64_rs1, out64_rs2, out64_rd;
    dec_ctrl_t   out64_ctrl;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    ysyx_idu_stage #(.XLEN(32), .SKID_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_pc(out_pc), .out_imm(out_imm), .out_rs1(out_rs1),
        .out_rs2(out_rs2), .out_rd(out_rd), .out_ctrl(out_ctrl)
    );

    ysyx_idu_stage #(.XLEN(64), .SKID_EN(1'b0)) dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in64_valid), .in_ready(in64_ready),
        .in_inst(in64_inst), .in_pc(in64_pc), .flush(1'b0), .out_valid(out64_valid),
        .out_ready(out64_ready), .out_pc(out64_pc), .out_imm(out64_imm), .out_rs1(out64_rs1),
        .out_rs2(out64_rs2), .out_rd(out64_rd), .out_ctrl(out64_ctrl)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic dec_ctrl_t mk(input logic wr_en, input logic [1:0] wr_sel, input logic jump,
                                     input logic [2:0] br, input logic a, input logic b,
                                     input logic [3:0] alu, input logic [2:0] rd_sel,
                                     input logic [1:0] dm_wr, input logic eb, input logic ec,
                                     input logic ill);
        dec_ctrl_t c;
        c.rf_wr_en = wr_en;  c.rf_wr_sel = wr_sel; c.do_jump   = jump;  c.br_type  = br;
        c.alu_a_sel = a;     c.alu_b_sel = b;      c.alu_ctrl  = alu;   c.dm_rd_sel = rd_sel;
        c.dm_wr_sel = dm_wr; c.is_ebreak = eb;     c.is_ecall  = ec;    c.illegal  = ill;
        return c;
    endfunction

    function automatic exp_t mx(input logic [31:0] pc, input logic [31:0] imm, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [4:0] rd, input dec_ctrl_t c);
        exp_t e;
        e.pc = pc; e.imm = imm; e.rs1 = rs1; e.rs2 = rs2; e.rd = rd; e.ctrl = c;
        return e;
    endfunction

    // Called 1 time unit after a rising edge; returns 1 time unit after the accepting edge.
    task automatic send(input logic [31:0] inst, input logic [31:0] pc, input bit push, input exp_t e);
        int n = 0;
        in_valid = 1'b1;
        in_inst  = inst;
        in_pc    = pc;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            chk("send_timeout_in_ready", 64'(in_ready), 64'd1);
        end else begin
            if (push) exp_q.push_back(e);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_pending", 64'(exp_q.size()), 64'd0);
    endtask

    // Monitor: pops expectations on every transfer and watches stall stability.
    initial begin
        exp_t        e;
        bit          held_vld = 1'b0;
        logic [31:0] held_pc, held_imm;
        dec_ctrl_t   held_ctrl;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                held_vld = 1'b0;
            end else begin
                if (held_vld && out_valid) begin
                    chk("stall_pc", 64'(out_pc), 64'(held_pc));
                    chk("stall_imm", 64'(out_imm), 64'(held_imm));
                    chk("stall_ctrl", 64'(out_ctrl), 64'(held_ctrl));
                end
                held_vld  = out_valid && !out_ready;
                held_pc   = out_pc;
                held_imm  = out_imm;
                held_ctrl = out_ctrl;
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_output: got pc 0x%0h expected no output", out_pc);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_pc", 64'(out_pc), 64'(e.pc));
                        chk("out_imm", 64'(out_imm), 64'(e.imm));
                        chk("out_rs1", 64'(out_rs1), 64'(e.rs1));
                        chk("out_rs2", 64'(out_rs2), 64'(e.rs2));
                        chk("out_rd", 64'(out_rd), 64'(e.rd));
                        chk("out_ctrl", 64'(out_ctrl), 64'(e.ctrl));
                    end
                end
            end
        end
    end

    initial begin
        dec_ctrl_t c_addi, c_ill;
        exp_t      none;
        none       = '0;
        c_addi     = mk(1, 2'b10, 0, 3'b000, 1, 1, 4'b0000, 3'b000, 2'b00, 0, 0, 0);
        c_ill      = mk(0, 2'b00, 0, 3'b000, 0, 0, 4'b0000, 3'b000, 2'b00, 0, 0, 1);
        rst_n      = 1'b1;
        in_valid   = 1'b0; in_inst = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b0;
        in64_valid = 1'b0; in64_inst = '0; in64_pc = '0; out64_ready = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_pc", 64'(out_pc), 64'd0);
        chk("rst_out_imm", 64'(out_imm), 64'd0);
        chk("rst_out_ctrl", 64'(out_ctrl), 64'd0);
        chk("rst_out_rd", 64'({out_rs1, out_rs2, out_rd}), 64'd0);
        @(negedge clk); #2 rst_n = 1'b1;
        @(posedge clk); #1;

        // Streaming decode of directed words.
        out_ready = 1'b1;
        send(32'h0050_0093, 32'h8000_0000, 1, mx(32'h8000_0000, 32'd5, 0, 5, 1, c_addi));
        chk("addi_latency_out_valid", 64'(out_valid), 64'd1);
        send(32'h0020_A423, 32'h8000_0004, 1, mx(32'h8000_0004, 32'd8, 1, 2, 8,
             mk(0, 2'b00, 0, 3'b000, 1, 1, 4'b0000, 3'b000, 2'b11, 0, 0, 0)));
        send(32'h0010_0073, 32'h8000_0008, 1, mx(32'h8000_0008, 32'd1, 0, 1, 0,
             mk(0, 2'b00, 0, 3'b000, 1, 1, 4'b0000, 3'b000, 2'b00, 1, 0, 0)));
        send(32'hFFFF_FFFF, 32'h8000_000C, 1, mx(32'h8000_000C, 32'd0, 31, 31, 31, c_ill));
        send(32'h0000_0013, 32'h8000_0010, 1, mx(32'h8000_0010, 32'd0, 0, 0, 0,
             mk(0, 2'b10, 0, 3'b000, 1, 1, 4'b0000, 3'b000, 2'b00, 0, 0, 0)));
        send(32'h4000_0093, 32'h8000_0014, 1, mx(32'h8000_0014, 32'h400, 0, 0, 1, c_addi));
        send(32'h4020_81B3, 32'h8000_0018, 1, mx(32'h8000_0018, 32'd0, 1, 2, 3,
             mk(1, 2'b10, 0, 3'b000, 1, 0, 4'b1000, 3'b000, 2'b00, 0, 0, 0)));
        send(32'h4033_5293, 32'h8000_001C, 1, mx(32'h8000_001C, 32'h403, 6, 3, 5,
             mk(1, 2'b10, 0, 3'b000, 1, 1, 4'b1101, 3'b000, 2'b00, 0, 0, 0)));
        send(32'h4000_1093, 32'h8000_0020, 1, mx(32'h8000_0020, 32'h400, 0, 0, 1, c_ill));
        send(32'h0020_8463, 32'h8000_0024, 1, mx(32'h8000_0024, 32'd8, 1, 2, 8,
             mk(0, 2'b00, 0, 3'b010, 0, 1, 4'b0000, 3'b000, 2'b00, 0, 0, 0)));
        send(32'hFFDF_F0EF, 32'h8000_0028, 1, mx(32'h8000_0028, 32'hFFFF_FFFC, 31, 29, 1,
             mk(1, 2'b01, 1, 3'b000, 0, 1, 4'b0000, 3'b000, 2'b00, 0, 0, 0)));
        send(32'hFF81_2203, 32'h8000_002C, 1, mx(32'h8000_002C, 32'hFFFF_FFF8, 2, 24, 4,
             mk(1, 2'b11, 0, 3'b000, 1, 1, 4'b0000, 3'b101, 2'b00, 0, 0, 0)));
        send(32'h1234_53B7, 32'h8000_0030, 1, mx(32'h8000_0030, 32'h1234_5000, 8, 3, 7,
             mk(1, 2'b10, 0, 3'b000, 0, 1, 4'b1110, 3'b000, 2'b00, 0, 0, 0)));
        send(32'h0000_0073, 32'h8000_0034, 1, mx(32'h8000_0034, 32'd0, 0, 0, 0,
             mk(0, 2'b00, 0, 3'b000, 1, 1, 4'b0000, 3'b000, 2'b00, 0, 1, 0)));
        wait_drain();

        // Backpressure: four back-to-back words while the EXU stalls three cycles.
        out_ready = 1'b0;
        fork
            begin
                send(32'h0010_0093, 32'h8000_0100, 1, mx(32'h8000_0100, 32'd1, 0, 1, 1, c_addi));
                send(32'h0020_0113, 32'h8000_0104, 1, mx(32'h8000_0104, 32'd2, 0, 2, 2, c_addi));
                send(32'h0030_0193, 32'h8000_0108, 1, mx(32'h8000_0108, 32'd3, 0, 3, 3, c_addi));
                send(32'h0040_0213, 32'h8000_010C, 1, mx(32'h8000_010C, 32'd4, 0, 4, 4, c_addi));
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                chk("bp_in_ready_full", 64'(in_ready), 64'd0);
                chk("bp_out_valid_held", 64'(out_valid), 64'd1);
                chk("bp_head_pc", 64'(out_pc), 64'h8000_0100);
                out_ready = 1'b1;
            end
        join
        wait_drain();

        // Flush in TWO with a simultaneous offer: nothing of it may surface.
        out_ready = 1'b0;
        send(32'h0070_0393, 32'h8000_0200, 0, none);
        send(32'h0080_0413, 32'h8000_0204, 0, none);
        chk("fl_in_ready_two", 64'(in_ready), 64'd0);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_inst  = 32'h0090_0493;
        in_pc    = 32'h8000_0208;
        @(posedge clk); #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl_out_valid", 64'(out_valid), 64'd0);
        chk("fl_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        send(32'h0050_0293, 32'h8000_0300, 1, mx(32'h8000_0300, 32'd5, 0, 5, 5, c_addi));
        wait_drain();

        // Asynchronous reset while full.
        out_ready = 1'b0;
        send(32'h0070_0393, 32'h8000_0400, 0, none);
        send(32'h0080_0413, 32'h8000_0404, 0, none);
        chk("rs_in_ready_two", 64'(in_ready), 64'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("rs_out_valid_async", 64'(out_valid), 64'd0);
        chk("rs_in_ready_async", 64'(in_ready), 64'd1);
        @(negedge clk); #2 rst_n = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(32'h0060_0313, 32'h8000_0500, 1, mx(32'h8000_0500, 32'd6, 0, 6, 6, c_addi));
        wait_drain();

        // 64-bit instance, single-register mode.
        chk("x64_in_ready_idle", 64'(in64_ready), 64'd1);
        in64_valid = 1'b1;
        in64_inst  = 32'hFFF0_0093;
        in64_pc    = 64'h0000_0001_0000_0000;
        @(posedge clk); #1;
        in64_valid = 1'b0;
        chk("x64_out_valid", 64'(out64_valid), 64'd1);
        chk("x64_imm", out64_imm, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("x64_pc", out64_pc, 64'h0000_0001_0000_0000);
        chk("x64_rd", 64'(out64_rd), 64'd1);
        out64_ready = 1'b0;
        #1;
        chk("x64_in_ready_stall", 64'(in64_ready), 64'd0);
        out64_ready = 1'b1;
        #1;
        chk("x64_in_ready_drain", 64'(in64_ready), 64'd1);
        @(posedge clk); #1;
        chk("x64_out_valid_after", 64'(out64_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_checks++;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
